// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - triangular-skew activation feeder for a systolic PE column
//
// Accepts one ROWS-wide activation vector per beat (valid/ready), delays lane r
// by r extra cycles, and drives each PE row. After the final beat of a tile
// (i_last, or DEPTH beats) zero vectors flush the skew pipe and o_done pulses.
//
// Optional feature macro: FEEDER_STATS_EN (adds o_bubble_cnt).
//
// Ports:
//   i_clock       single clock, all logic on posedge
//   i_reset_n     synchronous active-low reset
//   i_valid       input vector valid
//   i_data        ROWS*BW activations, lane r = i_data[r*BW +: BW]
//   i_last        final beat of tile (qualified by accept)
//   o_ready       feeder can accept a beat
//   o_act         skewed activations, registered
//   o_lane_valid  bit r: lane r holds an accepted beat
//   o_busy        tile in progress
//   o_done        one-cycle pulse when tile fully drained
//   o_overrun     sticky: DEPTH beats seen without i_last
//   o_bubble_cnt  (FEEDER_STATS_EN) saturating count of STREAM cycles without i_valid

module act_skew_feeder #(
    parameter int BW    = 8,
    parameter int ROWS  = 4,
    parameter int DEPTH = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [ROWS*BW-1:0]   i_data,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic [ROWS*BW-1:0]   o_act,
    output logic [ROWS-1:0]      o_lane_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]          o_bubble_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (ROWS > 2) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   cnt_next;
    logic [FW-1:0]   flush_cnt;
    logic            accept;
    logic            tile_end;

    assign o_ready  = (state != S_FLUSH);
    assign o_busy   = (state != S_IDLE);
    assign accept   = i_valid && o_ready;
    // First beat of a tile loads 1; later beats increment.
    assign cnt_next = (state == S_IDLE) ? CW'(1) : beat_cnt + CW'(1);
    assign tile_end = accept && (i_last || (cnt_next == CW'(DEPTH)));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_STREAM: begin
                if (tile_end) begin
                    state_nx = S_FLUSH;
                end else if (accept) begin
                    state_nx = S_STREAM;
                end
            end
            S_FLUSH: begin
                // Leave one cycle after o_done so its pulse overlaps the
                // last lane's final output.
                if (o_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                beat_cnt <= cnt_next;
            end
            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + FW'(1);
            end else begin
                flush_cnt <= '0;
            end
            o_done <= (state == S_FLUSH) && !o_done && (flush_cnt == FW'(ROWS - 2));
            if (accept && !i_last && (cnt_next == CW'(DEPTH))) begin
                o_overrun <= 1'b1;
            end
        end
    end

    // Lane r is an (r+1)-deep shift register; non-accepted cycles shift in zeros.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [BW-1:0] d_q [0:r];
        logic [r:0]    v_q;

        always_ff @(posedge i_clock) begin
            if (!i_reset_n) begin
                for (int k = 0; k <= r; k++) begin
                    d_q[k] <= '0;
                end
                v_q <= '0;
            end else begin
                d_q[0] <= accept ? i_data[r*BW +: BW] : '0;
                v_q[0] <= accept;
                for (int k = 1; k <= r; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign o_act[r*BW +: BW] = d_q[r];
        assign o_lane_valid[r]   = v_q[r];
    end

`ifdef FEEDER_STATS_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            o_bubble_cnt <= '0;
        end else if ((state == S_IDLE) && (state_nx == S_STREAM)) begin
            o_bubble_cnt <= '0;
        end else if ((state == S_STREAM) && !i_valid && (o_bubble_cnt != 16'hFFFF)) begin
            o_bubble_cnt <= o_bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb/tb_act_skew_feeder.sv - self-checking bench for act_skew_feeder

module tb_act_skew_feeder;

    localparam int BW    = 8;
    localparam int ROWS  = 4;
    localparam int DEPTH = 16;
    localparam int NW    = ROWS * BW;
`ifdef FEEDER_STATS_EN
    localparam int VW = NW + ROWS + 4 + 16;
`else
    localparam int VW = NW + ROWS + 4;
`endif

    logic            clk;
    logic            i_reset_n;
    logic            i_valid;
    logic [NW-1:0]   i_data;
    logic            i_last;
    logic            o_ready;
    logic [NW-1:0]   o_act;
    logic [ROWS-1:0] o_lane_valid;
    logic            o_busy;
    logic            o_done;
    logic            o_overrun;
`ifdef FEEDER_STATS_EN
    logic [15:0]     o_bubble_cnt;
`endif

    act_skew_feeder #(.BW(BW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .i_clock      (clk),
        .i_reset_n    (i_reset_n),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_ready      (o_ready),
        .o_act        (o_act),
        .o_lane_valid (o_lane_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun)
`ifdef FEEDER_STATS_EN
        ,
        .o_bubble_cnt (o_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: history of what was accepted at each edge, plus tile bookkeeping.
    logic [NW-1:0] hd [0:8191];
    bit            hv [0:8191];
    int            cyc   = 0;
    int            base  = 0;
    int            tend  = -1000;
    int            beats = 0;
    bit            m_ready = 1'b1;
    bit            m_done, m_busy, m_ovr;
    logic [15:0]   m_bub = '0;
    logic [VW-1:0] exp_vec;
    logic [VW-1:0] obs;

`ifdef FEEDER_STATS_EN
    assign obs = {o_act, o_lane_valid, o_done, o_busy, o_ready, o_overrun, o_bubble_cnt};
`else
    assign obs = {o_act, o_lane_valid, o_done, o_busy, o_ready, o_overrun};
`endif

    task automatic tick(input bit rst, input bit v, input logic [NW-1:0] d, input bit last);
        bit              acc;
        bit              flushing;
        logic [NW-1:0]   ea;
        logic [ROWS-1:0] ev;
        int              idx;
        i_reset_n = !rst;
        i_valid   = v;
        i_data    = d;
        i_last    = last;
        @(posedge clk);
        #1;
        cyc++;
        acc = !rst && v && m_ready;
        if (rst) begin
            base  = cyc;
            hd[cyc] = '0;
            hv[cyc] = 1'b0;
            tend  = -1000;
            beats = 0;
            m_ovr = 1'b0;
            m_bub = '0;
        end else begin
            hd[cyc] = acc ? d : '0;
            hv[cyc] = acc;
            if (beats > 0 && !v && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
            if (acc) begin
                if (beats == 0 && !last) m_bub = '0;
                beats++;
                if (last || beats == DEPTH) begin
                    if (!last) m_ovr = 1'b1;
                    tend  = cyc;
                    beats = 0;
                end
            end
        end
        flushing = (cyc >= tend) && (cyc <= tend + ROWS - 1);
        m_ready  = !flushing;
        m_done   = (cyc == tend + ROWS - 1);
        m_busy   = (beats > 0) || flushing;
        ea = '0;
        ev = '0;
        for (int r = 0; r < ROWS; r++) begin
            idx = cyc - r;
            if (idx >= base) begin
                ea[r*BW +: BW] = hd[idx][r*BW +: BW];
                ev[r]          = hv[idx];
            end
        end
`ifdef FEEDER_STATS_EN
        exp_vec = {ea, ev, m_done, m_busy, m_ready, m_ovr, m_bub};
`else
        exp_vec = {ea, ev, m_done, m_busy, m_ready, m_ovr};
`endif
    endtask

    function automatic logic [NW-1:0] rnd_vec();
        logic [NW-1:0] x;
        x = NW'($urandom);
        return x;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, rnd_vec(), 1'b0);
            n_cmp++;
            if (o_act !== '0 || o_lane_valid !== '0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_const act=%h lv=%b busy=%b ready=%b required 0/0/0/1",
                         o_act, o_lane_valid, o_busy, o_ready);
            end
        end
        tick(1'b0, 1'b0, '0, 1'b0);
        n_cmp++;
        if (obs !== exp_vec) begin
            n_bad++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
        end
    endtask

    task automatic test_single();
        tick(1'b0, 1'b1, 32'h04030201, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick(1'b0, 1'b0, '0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL single k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            if (k == 3) begin
                n_cmp++;
                if (o_act[31:24] !== 8'd4 || o_done !== 1'b1) begin
                    n_bad++;
                    $display("FAIL single_lane3 lane3=%0d done=%b required 4/1", o_act[31:24], o_done);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (o_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL single_busy busy=%b required 0", o_busy);
                end
            end
        end
    endtask

    task automatic test_bubble();
        bit vs [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 10; k++) begin
            if (k < 4) tick(1'b0, vs[k], rnd_vec(), k == 3);
            else       tick(1'b0, 1'b0, '0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL bubble k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_overrun();
        logic [NW-1:0] d;
        bit            rdy;
        d = rnd_vec();
        for (int k = 0; k < 24; k++) begin
            rdy = m_ready;
            tick(1'b0, 1'b1, d, k >= 16);
            if (rdy) d = rnd_vec();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL overrun k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            if (k == 16) begin
                n_cmp++;
                if (o_overrun !== 1'b1 || o_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL overrun_hold ovr=%b ready=%b required 1/0", o_overrun, o_ready);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL overrun_drain k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, rnd_vec(), 1'b0);
        tick(1'b0, 1'b1, rnd_vec(), 1'b0);
        tick(1'b1, 1'b1, rnd_vec(), 1'b0);
        n_cmp++;
        if (o_act !== '0 || o_lane_valid !== '0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_clear act=%h lv=%b done=%b busy=%b ovr=%b required all 0",
                     o_act, o_lane_valid, o_done, o_busy, o_overrun);
        end
        for (int k = 0; k < 12; k++) begin
            if (k < 3) tick(1'b0, 1'b1, rnd_vec(), k == 2);
            else       tick(1'b0, 1'b0, '0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
        end
    endtask

`ifdef FEEDER_STATS_EN
    task automatic test_stats();
        int nb;
        nb = 0;
        for (int k = 0; k < 21; k++) begin
            if (k < 10 && k[0]) begin
                tick(1'b0, 1'b0, '0, 1'b0);
            end else if (nb < 10) begin
                nb++;
                tick(1'b0, 1'b1, rnd_vec(), nb == 10);
            end else begin
                tick(1'b0, 1'b0, '0, 1'b0);
            end
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL stats k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
        end
        n_cmp++;
        if (o_bubble_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL stats_bubble got=%0d required 5", o_bubble_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [NW-1:0] d;
        bit            v, l, rdy;
        d = rnd_vec();
        for (int k = 0; k < 400; k++) begin
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 5) == 0);
            rdy = m_ready;
            tick(1'b0, v, d, l);
            if (rdy && v) d = rnd_vec();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
        end
        for (int k = 0; k < 24; k++) begin
            tick(1'b0, 1'b1, d, 1'b1);
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL random_end k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_last    = 1'b0;
        test_reset();
        test_single();
        test_bubble();
        test_overrun();
        test_reset_mid();
`ifdef FEEDER_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
